// File: rtl/bus_pack_fifo_if.sv
// -----------------------------------------------------------------------------
// bus_pack_fifo_if
//
// Purpose : Groups the write (SHA3 core side) and read (bus side) signals of
//           bus_pack_fifo into one bundle so they travel together.
//
// Signals :
//   write_data     [63:0]   word to pack
//   write_en                one word offered per cycle
//   read                    pop the head entry
//   read_data      [127:0]  head entry, show-ahead
//   fifo_full               entry count == DEPTH
//   fifo_half_full          entry count >= DEPTH/2
//   fifo_empty              entry count == 0
//   word_pending            low half captured, upper half not yet written
//   flush                   only with BUS_PACK_FIFO_FLUSH_EN: push a lone
//                           pending half with a zero upper half
//
// Modports:
//   master - the side that writes words and pops entries
//   slave  - the FIFO itself
//
// Optional feature macro: BUS_PACK_FIFO_FLUSH_EN
// -----------------------------------------------------------------------------
interface bus_pack_fifo_if;
    logic [63:0]  write_data;
    logic         write_en;
    logic         read;
    logic [127:0] read_data;
    logic         fifo_full;
    logic         fifo_half_full;
    logic         fifo_empty;
    logic         word_pending;
`ifdef BUS_PACK_FIFO_FLUSH_EN
    logic         flush;

    modport master (
        output write_data, write_en, read, flush,
        input  read_data, fifo_full, fifo_half_full, fifo_empty, word_pending
    );

    modport slave (
        input  write_data, write_en, read, flush,
        output read_data, fifo_full, fifo_half_full, fifo_empty, word_pending
    );
`else
    modport master (
        output write_data, write_en, read,
        input  read_data, fifo_full, fifo_half_full, fifo_empty, word_pending
    );

    modport slave (
        input  write_data, write_en, read,
        output read_data, fifo_full, fifo_half_full, fifo_empty, word_pending
    );
`endif
endinterface : bus_pack_fifo_if

// File: rtl/bus_pack_fifo.sv
// -----------------------------------------------------------------------------
// bus_pack_fifo
//
// Purpose : Width-up FIFO on the return path from the SHA3 core to the bus.
//           Pairs of 64-bit words are packed into 128-bit entries: the first
//           word of a pair fills [63:0] and the second fills [127:64]. The
//           read side is show-ahead: the head entry is always on read_data and
//           read pops it.
//
// Ports   :
//   clk    in   clock, all state updates on the rising edge
//   rst    in   synchronous active-low reset
//   bus    slave modport of bus_pack_fifo_if (write/read data, strobes, flags)
//
// Parameter:
//   DEPTH  number of 128-bit entries; power of 2, at least 2
//
// Optional feature macro: BUS_PACK_FIFO_FLUSH_EN
//   When defined, bus.flush pushes a lone pending low half as {64'h0, lo}.
//   When undefined, a trailing odd word stays pending until its partner
//   arrives.
// -----------------------------------------------------------------------------
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   LOW   | no half held; next accepted word is captured into lo_reg
//   HIGH  | lo_reg holds the low half; next accepted word completes the
//         | pair and pushes one entry (or a flush pushes it zero-padded)
//
module bus_pack_fifo #(
    parameter int DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    bus_pack_fifo_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_HALF = (AW + 1)'(DEPTH / 2);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } pack_state_t;

    pack_state_t    state;
    pack_state_t    state_nxt;

    logic [127:0]   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic [63:0]    lo_reg;

    logic           full;
    logic           empty;
    logic           wr_acc;
    logic           pop;
    logic           push;
    logic           lo_load;
    logic [127:0]   push_data;

    // Flags come straight from the registered count, so they move one cycle
    // after the edge that changed it.
    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

    // A full FIFO refuses every write, even with a pop in the same cycle:
    // the pop frees the slot only after the edge.
    assign wr_acc = bus.write_en && !full;
    assign pop    = bus.read && !empty;

    // Pack FSM: next state and push/capture decisions.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        lo_load   = 1'b0;
        push_data = {64'h0, lo_reg};
        case (state)
            LOW: begin
                if (wr_acc) begin
                    lo_load   = 1'b1;
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (wr_acc) begin
                    push      = 1'b1;
                    push_data = {bus.write_data, lo_reg};
                    state_nxt = LOW;
                end
`ifdef BUS_PACK_FIFO_FLUSH_EN
                // A real write always wins over flush in the same cycle.
                else if (bus.flush && !full) begin
                    push      = 1'b1;
                    push_data = {64'h0, lo_reg};
                    state_nxt = LOW;
                end
`endif
            end
            default: begin
                state_nxt = LOW;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= LOW;
            lo_reg <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_nxt;
            if (lo_load) begin
                lo_reg <= bus.write_data;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; entries are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign bus.read_data      = mem[rd_ptr];
    assign bus.fifo_full      = full;
    assign bus.fifo_half_full = (count >= CNT_HALF);
    assign bus.fifo_empty     = empty;
    assign bus.word_pending   = (state == HIGH);

endmodule : bus_pack_fifo

// File: tb/tb_bus_pack_fifo.sv
// -----------------------------------------------------------------------------
// tb_bus_pack_fifo
//
// Purpose : Self-checking bench for bus_pack_fifo (DEPTH = 8). Directed steps
//           followed by random traffic, compared against a queue-based model
//           of a packing FIFO. Flush steps are included only when
//           BUS_PACK_FIFO_FLUSH_EN is defined.
// -----------------------------------------------------------------------------
module tb_bus_pack_fifo;

    localparam int DEPTH = 8;

`ifdef BUS_PACK_FIFO_FLUSH_EN
    localparam bit HAS_FLUSH = 1'b1;
`else
    localparam bit HAS_FLUSH = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bus_pack_fifo_if bus ();

    bus_pack_fifo #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: entries in arrival order plus the held low half.
    logic [127:0] mq[$];
    logic [63:0]  m_lo;
    bit           m_pend;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string where);
        chk({where, ":empty"},   128'(bus.fifo_empty),     128'(mq.size() == 0));
        chk({where, ":full"},    128'(bus.fifo_full),      128'(mq.size() == DEPTH));
        chk({where, ":half"},    128'(bus.fifo_half_full), 128'(mq.size() >= DEPTH / 2));
        chk({where, ":pending"}, 128'(bus.word_pending),   128'(m_pend));
        if (mq.size() > 0) begin
            chk({where, ":head"}, bus.read_data, mq[0]);
        end
    endtask

    // One clock of stimulus; the model applies the same cycle's rules.
    task automatic drive(input logic we, input logic [63:0] wd, input logic rd,
                         input logic fl, input string where);
        bit           was_full;
        bit           was_empty;
        bit           do_push;
        logic [127:0] entry;
        bus.write_en   = we;
        bus.write_data = wd;
        bus.read       = rd;
`ifdef BUS_PACK_FIFO_FLUSH_EN
        bus.flush      = fl;
`endif
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        do_push   = 1'b0;
        entry     = '0;
        if (we && !was_full) begin
            if (!m_pend) begin
                m_lo   = wd;
                m_pend = 1'b1;
            end else begin
                entry   = {wd, m_lo};
                do_push = 1'b1;
                m_pend  = 1'b0;
            end
        end else if (fl && HAS_FLUSH && m_pend && !was_full) begin
            entry   = {64'h0, m_lo};
            do_push = 1'b1;
            m_pend  = 1'b0;
        end
        if (rd && !was_empty) begin
            void'(mq.pop_front());
        end
        if (do_push) begin
            mq.push_back(entry);
        end
        @(posedge clk);
        #1;
        check_state(where);
    endtask

    task automatic do_reset(input int n);
        rst            = 1'b0;
        bus.write_en   = 1'b0;
        bus.write_data = '0;
        bus.read       = 1'b0;
`ifdef BUS_PACK_FIFO_FLUSH_EN
        bus.flush      = 1'b0;
`endif
        repeat (n) @(posedge clk);
        #1;
        mq.delete();
        m_lo   = '0;
        m_pend = 1'b0;
        check_state("reset");
        rst = 1'b1;
    endtask

    initial begin
        logic [63:0] rd_word;
        bit          we_r;
        bit          rd_r;
        bit          fl_r;

        m_lo   = '0;
        m_pend = 1'b0;

        // Reset held for 5 cycles.
        do_reset(5);
        chk("rst_empty",   128'(bus.fifo_empty),     128'(1));
        chk("rst_pending", 128'(bus.word_pending),   128'(0));

        // Fill with 16 words, pending toggling every cycle.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 64'(i), 1'b0, 1'b0, "fill");
            chk("fill_toggle", 128'(bus.word_pending), 128'(i % 2 == 0));
            if (i == 7) chk("half_after_7", 128'(bus.fifo_half_full), 128'(1));
            if (i == 14) chk("notfull_at_14", 128'(bus.fifo_full), 128'(0));
        end
        chk("full_after_F", 128'(bus.fifo_full), 128'(1));
        chk("fill_head", bus.read_data, {64'h1, 64'h0});

        // Drain with read held.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 64'h0, 1'b1, 1'b0, "drain");
            if (i == 0) chk("notfull_after_pop", 128'(bus.fifo_full), 128'(0));
            if (i == 4) chk("nothalf_at_3", 128'(bus.fifo_half_full), 128'(0));
            if (i == 6) chk("last_head", bus.read_data, {64'hF, 64'hE});
        end
        chk("empty_after_8", 128'(bus.fifo_empty), 128'(1));

        // Write while full together with a read: write dropped, one pop.
        for (int i = 0; i < 16; i++) drive(1'b1, 64'(i + 16), 1'b0, 1'b0, "refill");
        drive(1'b1, 64'hAA, 1'b1, 1'b0, "wr_full");
        chk("wr_full_pending", 128'(bus.word_pending), 128'(0));
        chk("wr_full_popped",  128'(bus.fifo_full),    128'(0));
        for (int i = 0; i < 8; i++) drive(1'b0, 64'h0, 1'b1, 1'b0, "drain_aa");
        chk("drain_aa_empty", 128'(bus.fifo_empty), 128'(1));

        // Concurrent traffic.
        drive(1'b1, 64'h0, 1'b0, 1'b0, "conc");
        drive(1'b1, 64'h1, 1'b0, 1'b0, "conc");
        chk("conc_head01", bus.read_data, {64'h1, 64'h0});
        drive(1'b1, 64'h2, 1'b1, 1'b0, "conc");
        drive(1'b1, 64'h3, 1'b1, 1'b0, "conc");
        chk("conc_head23", bus.read_data, {64'h3, 64'h2});
        chk("conc_not_half", 128'(bus.fifo_half_full), 128'(0));
        drive(1'b0, 64'h0, 1'b1, 1'b0, "conc");
        chk("conc_empty", 128'(bus.fifo_empty), 128'(1));

        // Reset mid-pack drops the pending half.
        drive(1'b1, 64'h5, 1'b0, 1'b0, "midpack");
        chk("midpack_pending", 128'(bus.word_pending), 128'(1));
        do_reset(1);
        chk("midpack_cleared", 128'(bus.word_pending), 128'(0));
        drive(1'b1, 64'h6, 1'b0, 1'b0, "midpack");
        drive(1'b1, 64'h7, 1'b0, 1'b0, "midpack");
        chk("midpack_head", bus.read_data, {64'h7, 64'h6});
        drive(1'b0, 64'h0, 1'b1, 1'b0, "midpack");

`ifdef BUS_PACK_FIFO_FLUSH_EN
        drive(1'b1, 64'h9, 1'b0, 1'b0, "flush");
        drive(1'b0, 64'h0, 1'b0, 1'b1, "flush");
        chk("flush_head",    bus.read_data,            {64'h0, 64'h9});
        chk("flush_pending", 128'(bus.word_pending),   128'(0));
        drive(1'b0, 64'h0, 1'b0, 1'b1, "flush_noop");
        chk("flush_noop_half", 128'(bus.fifo_half_full), 128'(0));
        drive(1'b0, 64'h0, 1'b1, 1'b0, "flush_noop");
        chk("flush_noop_empty", 128'(bus.fifo_empty), 128'(1));
`endif

        // Random traffic: write-heavy phase, then read-heavy phase.
        for (int i = 0; i < 400; i++) begin
            if (i < 200) begin
                we_r = ($urandom_range(0, 3) != 0);
                rd_r = ($urandom_range(0, 3) == 0);
            end else begin
                we_r = ($urandom_range(0, 3) == 0);
                rd_r = ($urandom_range(0, 3) != 0);
            end
            fl_r    = ($urandom_range(0, 7) == 0);
            rd_word = {$urandom, $urandom};
            if ($urandom_range(0, 149) == 0) begin
                do_reset(1);
            end else begin
                drive(we_r, rd_word, rd_r, fl_r, "rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_bus_pack_fifo

// File: doc/bus_pack_fifo.md
Name: bus_pack_fifo

Overview:
- Width-up FIFO; the return-path counterpart of the 128-to-64 bus FIFO.
- Accepts 64-bit words from the SHA3 core side and packs each pair into one 128-bit entry for the bus side.
- First word written lands in bits [63:0]; second word lands in bits [127:64].
- Read side is show-ahead: the head entry is always presented on read_data, and read pops it.

Parameters:
- DEPTH, 8, number of 128-bit entries. Power of 2, minimum 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset; sampled on rising clk edge.
- write_data  in  64  word to pack.
- write_en  in  1  write strobe; one word accepted per cycle when not full.
- read  in  1  pop head entry; honoured only when not empty.
- read_data  out  128  head entry; show-ahead (valid whenever fifo_empty=0).
- fifo_full  out  1  count == DEPTH.
- fifo_half_full  out  1  count >= DEPTH/2.
- fifo_empty  out  1  count == 0.
- word_pending  out  1  low half held in pack register, upper half not yet written.

Behaviour:
- State:
  - mem[DEPTH] x 128.
  - wr_ptr, rd_ptr: log2(DEPTH) bits, wrap naturally.
  - count: log2(DEPTH)+1 bits.
  - lo_reg: 64 bits.
  - pending: 1 bit.
- Reset (rst=0 at posedge): wr_ptr=rd_ptr=count=0, pending=0, lo_reg=0.
  - Outputs after reset: fifo_empty=1, fifo_full=0, fifo_half_full=0, word_pending=0, read_data=mem[0] (don't-care while empty).
  - Reset mid-operation discards all stored entries and any pending half.
- Pack FSM, two states: LOW (pending=0) and HIGH (pending=1).
  - LOW, write accepted: lo_reg<=write_data; go to HIGH. No push.
  - HIGH, write accepted: mem[wr_ptr]<={write_data, lo_reg}; wr_ptr++; go to LOW.
- Write acceptance: write_en=1 and fifo_full=0.
  - When full, a write is ignored in either state: no state change, and the word is dropped.
  - The writer must check fifo_full.
- Pop: read=1 and fifo_empty=0 -> rd_ptr++. A read while empty is ignored.
- Count, per cycle: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
- Flags are decoded combinationally from registered count, so they update the cycle after the causing edge.
- read_data = mem[rd_ptr], combinational from registered state.
  - A push into an empty FIFO is visible on read_data one cycle after the completing write edge.
  - Latency from second word written to entry readable: 1 clock.
- Simultaneous events:
  - Write completing a pair while full is rejected even if read=1 in the same cycle; no same-cycle pass-through of full.
  - Read+write when not full: both take effect.
  - Read while empty with a completing write: push occurs, read ignored.
- Pointer wrap: ptr DEPTH-1 -> 0; no special handling.

Optional Feature:
- Macro: BUS_PACK_FIFO_FLUSH_EN.
- With the macro defined, an extra input port is added: flush, in, 1.
  - On flush=1, pending=1, fifo_full=0: push {64'h0, lo_reg} and clear pending.
  - If write_en is also high that cycle, the write takes priority: it completes the pair normally and flush is ignored.
  - flush with pending=0 is a no-op. flush while full is ignored.
- Without the macro: no flush port, and a trailing odd word stays pending until its partner is written.

Test Plan:
- Reset: hold rst=0 for 5 cycles, then release -> fifo_empty=1, fifo_full=0, fifo_half_full=0, word_pending=0.
- Fill then drain, DEPTH=8:
  - Write 64'h0..64'hF on 16 consecutive cycles -> word_pending toggles each cycle; fifo_half_full=1 after word 64'h7; fifo_full=1 after word 64'hF.
  - Then hold read=1 -> read_data sequence {64'h1,64'h0}, {64'h3,64'h2}, ..., {64'hF,64'hE}; fifo_full=0 after first pop; fifo_half_full=0 once count=3; fifo_empty=1 after the 8th pop.
- Write while full: with FIFO full, write 64'hAA with write_en=1 and read=1 together -> one entry popped, word_pending unchanged, 64'hAA never appears in the subsequent drain.
- Concurrent traffic:
  - Write 64'h0, 64'h1 -> read_data={64'h1,64'h0} next cycle.
  - Assert read while writing 64'h2, 64'h3 -> next head is {64'h3,64'h2}; count never exceeds 1; fifo_empty=1 after final pop.
- Reset mid-pack: write 64'h5 (word_pending=1), then pulse rst=0 for 1 cycle -> word_pending=0, fifo_empty=1. Then write 64'h6, 64'h7 -> read_data={64'h7,64'h6}.
- (BUS_PACK_FIFO_FLUSH_EN) Write 64'h9, then flush=1 for 1 cycle -> read_data={64'h0,64'h9}, word_pending=0. A second flush while word_pending=0 -> count unchanged.
